// File: rtl/rcc_char_uart_tx_if.sv
// Character-in / serial-out bundle between the RCC stage, the UART transmitter and debug status.
interface rcc_char_uart_tx_if;
  logic [7:0]  dout;
  logic        dout_flag;
  logic        digit_clk;
  logic        ovf_clr;
  logic        tx;
  logic        busy;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic [15:0] tx_count;

  modport master (
    output dout, dout_flag, digit_clk, ovf_clr,
    input  tx, busy, fifo_full, fifo_empty, overflow, tx_count
  );

  modport slave (
    input  dout, dout_flag, digit_clk, ovf_clr,
    output tx, busy, fifo_full, fifo_empty, overflow, tx_count
  );
endinterface

// File: rtl/rcc_char_uart_tx.sv
// RCC character capture FIFO and 8N1-style UART serializer with sticky overflow and sent-frame counter.

// Purpose: generic synchronous FIFO, power-of-2 depth, registered full/empty.
// Latency: written entry is visible (empty low) the cycle after the push.
// Backpressure: push while full is refused unless a pop happens the same cycle.
module rcc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt, cnt_nxt;
  logic             do_push, do_pop;

  assign do_pop  = pop_rdy & ~empty;
  assign do_push = push_vld & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (do_push && !do_pop)
      cnt_nxt = cnt + 1'b1;
    else if (!do_push && do_pop)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage needs no reset: discarded contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Purpose: capture RCC characters on digit_clk rising edges and send them as UART frames.
// Latency: push edge -> FIFO valid next cycle -> start bit on tx the cycle after.
// Backpressure: none upstream; characters arriving at a full FIFO are dropped and flagged.
module rcc_char_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input logic               clk,
  input logic               reset,
  rcc_char_uart_tx_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          tx_q, tx_nxt, busy_q, busy_nxt;
  logic [15:0]   tx_count;
  logic          dclk_q, push_vld, pop_rdy, sent, last_tick;
  logic          fifo_full, fifo_empty, ovf_q;
  logic [7:0]    pop_dat;

  assign push_vld  = bus.digit_clk & ~dclk_q & ~bus.dout_flag;
  assign last_tick = (timer == TW'(CLKS_PER_BIT - 1));

  rcc_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (bus.dout),
    .pop_rdy  (pop_rdy),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dclk_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dclk_q <= bus.digit_clk;
      if (push_vld && fifo_full && !pop_rdy)
        ovf_q <= 1'b1;
      else if (bus.ovf_clr)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      tx_count <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      bit_idx  <= bit_nxt;
      shreg    <= sh_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= busy_nxt;
      tx_count <= tx_count + {15'd0, sent};
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    pop_rdy   = 1'b0;
    sent      = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop_rdy   = 1'b1;
          sh_nxt    = pop_dat;
          state_nxt = START;
          timer_nxt = '0;
          bit_nxt   = '0;
        end
      end
      START: begin
        if (last_tick) begin
          timer_nxt = '0;
          state_nxt = DATA;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      DATA: begin
        if (last_tick) begin
          timer_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_idx + 1'b1;
            sh_nxt  = {1'b0, shreg[7:1]};
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      STOP: begin
        if (last_tick) begin
          timer_nxt = '0;
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            state_nxt = IDLE;
            sent      = 1'b1;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx/busy are decoded from the next state so the line itself comes straight off a flop.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.overflow   = ovf_q;
  assign bus.tx_count   = tx_count;
endmodule
